// File: rtl/height_sequencer.sv
// -----------------------------------------------------------------------------
// height_sequencer
//
// Purpose:
//   Front end for the height computation path. It polls the four drop-zone
//   sensors in turn over one shared read port and captures one reading from
//   each. It then averages the valid sensor pairs into an 8-bit height and
//   offers that height downstream on a valid/ready handshake. A per-read
//   timeout keeps a dead sensor from stalling the frame; a timed-out read
//   counts as 0.
//
// Parameters:
//   TIMEOUT      REQ cycles allowed per sensor before the read is abandoned
//                (1..255).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begin a measurement frame (sampled only while idle)
//   busy         high whenever a frame is in progress or a result is pending
//   sensor_sel   index of the sensor being read (0..3)
//   sensor_req   read request on the shared sensor port
//   sensor_ack   sensor read complete; sensor_data valid this cycle
//   sensor_data  reading from the selected sensor
//   height       computed height; holds until the next calculation
//   height_valid height offered downstream
//   height_ready downstream accepts height
//   timeout_err  a read in the current or last frame timed out
// -----------------------------------------------------------------------------
module height_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic [1:0] sensor_sel,
  output logic       sensor_req,
  input  logic       sensor_ack,
  input  logic [7:0] sensor_data,
  output logic [7:0] height,
  output logic       height_valid,
  input  logic       height_ready,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    CALC,
    OUT
  } state_t;

  // Counter value seen during the last REQ cycle allowed for one read.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q;
  logic [7:0] cnt_q;
  logic [7:0] slot_q [4];
  logic [7:0] height_q;
  logic       err_q;

  logic       ack_hit;
  logic       timeout_hit;
  logic       read_done;
  logic [7:0] height_d;

  // An ack on the final allowed cycle wins over the timeout.
  assign ack_hit     = (state_q == REQ) && sensor_ack;
  assign timeout_hit = (state_q == REQ) && !sensor_ack && (cnt_q == TO_LAST);
  assign read_done   = ack_hit || timeout_hit;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps this purely combinational;
  // a path that left state_d unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ:  if (read_done) state_d = (sel_q == 2'd3) ? CALC : GAP;
      GAP:  state_d = REQ;
      CALC: state_d = OUT;
      OUT:  if (height_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy         = 1'b1;
    sensor_req   = 1'b0;
    height_valid = 1'b0;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      REQ:     sensor_req = 1'b1;
      OUT:     height_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pair-validity averaging
  //   A = slot0 + slot2, B = slot1 + slot3; a pair counts only when both
  //   members are nonzero. One valid pair: halve with round-up. Two valid
  //   pairs: quarter with round-half-up. Neither: 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic       a_ok, b_ok;
    logic [9:0] pair_a, pair_b, sum;

    a_ok   = (slot_q[0] != 8'd0) && (slot_q[2] != 8'd0);
    b_ok   = (slot_q[1] != 8'd0) && (slot_q[3] != 8'd0);
    pair_a = {2'b00, slot_q[0]} + {2'b00, slot_q[2]};
    pair_b = {2'b00, slot_q[1]} + {2'b00, slot_q[3]};
    sum    = (a_ok ? pair_a : 10'd0) + (b_ok ? pair_b : 10'd0);

    // Sum is at most 1020, so +2 still fits in 10 bits.
    unique case ({a_ok, b_ok})
      2'b11:        height_d = 8'((sum + 10'd2) >> 2);
      2'b10, 2'b01: height_d = 8'((sum + 10'd1) >> 1);
      default:      height_d = 8'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 2'd0;
      cnt_q    <= 8'd0;
      height_q <= 8'd0;
      err_q    <= 1'b0;
      // NOTE: the slot storage is only four bytes and must read 0 after
      // reset, so it is reset explicitly rather than left to power-up.
      for (int i = 0; i < 4; i++) slot_q[i] <= 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sel_q <= 2'd0;
            cnt_q <= 8'd0;
            err_q <= 1'b0;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (ack_hit) begin
            slot_q[sel_q] <= sensor_data;
          end else if (timeout_hit) begin
            slot_q[sel_q] <= 8'd0;
            err_q         <= 1'b1;
          end
        end
        GAP: begin
          sel_q <= sel_q + 2'd1;
          cnt_q <= 8'd0;
        end
        CALC:    height_q <= height_d;
        default: ;
      endcase
    end
  end

  assign sensor_sel  = sel_q;
  assign height      = height_q;
  assign timeout_err = err_q;

endmodule

// File: doc/height_sequencer.md
# height_sequencer

Sequential front end for the height computation path. It time-multiplexes one shared sensor read port across the four drop-zone sensors and captures one reading from each. It then applies the pair-validity averaging rule and hands the resulting 8-bit height downstream over a valid/ready handshake. A per-read timeout guards against a dead sensor.

## Interface
Parameters:
- `TIMEOUT`, default 15: REQ cycles allowed per sensor before its read is abandoned; legal range 1–255.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: begin a measurement frame; sampled only in IDLE.
- `busy`, output, 1: high in every state except IDLE.
- `sensor_sel`, output, 2: sensor index being read (0 = sensor1 … 3 = sensor4).
- `sensor_req`, output, 1: read request on the shared port.
- `sensor_ack`, input, 1: sensor read done; `sensor_data` valid this cycle.
- `sensor_data`, input, 8: reading from the selected sensor.
- `height`, output, 8: computed height; holds until the next CALC.
- `height_valid`, output, 1: `height` offered downstream.
- `height_ready`, input, 1: downstream accepts `height`.
- `timeout_err`, output, 1: at least one read in the current or last frame timed out.

## Operation
- **States:** IDLE, REQ, GAP, CALC, OUT.
- **IDLE:**
  - `start` = 1 → REQ, `sensor_sel` = 0, `timeout_err` cleared, timeout counter cleared.
  - `start` in any other state is ignored.
- **REQ:**
  - `sensor_req` = 1; the timeout counter increments each REQ cycle.
  - `sensor_ack` = 1 → slot[`sensor_sel`] ← `sensor_data`.
  - Counter reaches `TIMEOUT` with no ack → slot ← 0 and `timeout_err` ← 1.
  - Ack in the same cycle as the timeout: the ack wins; data is captured and no error is flagged.
  - After capture or timeout: `sensor_sel` = 3 → CALC; otherwise → GAP.
- **GAP:**
  - One cycle with `sensor_req` = 0.
  - `sensor_sel` increments and the counter clears at GAP exit; → REQ.
- **CALC:** one cycle; compute `height` per the arithmetic rules below → OUT.
- **OUT:**
  - `height_valid` = 1.
  - `height_valid` && `height_ready` → IDLE, `height_valid` low the next cycle.
- **Arithmetic:**
  - Pair A = slot0 + slot2; pair B = slot1 + slot3.
  - A pair is valid only if both members are nonzero.
  - sum = sum of valid pairs, 10 bits, no overflow; n = 2 × number of valid pairs.
  - n = 0 → `height` = 0.
  - n = 2 → `height` = (sum + 1) >> 1, i.e. round up on an odd sum.
  - n = 4 → `height` = (sum + 2) >> 2, i.e. +1 when sum bit1 = 1.
  - Result always fits in 8 bits; the maximum is 255.
- **Slots:** cleared at reset only; every frame overwrites all four.

## Timing
- **Reset values:**
  - State IDLE; `busy` = 0, `sensor_req` = 0, `sensor_sel` = 0.
  - `height` = 0, `height_valid` = 0, `timeout_err` = 0.
  - Slots and counter = 0.
- **Reset mid-frame:** next cycle everything is at reset values; a pending `height_valid` is dropped.
- **Latency:**
  - `start` sampled at edge 0; `sensor_req` high from cycle 1.
  - With single-cycle acks: REQ in cycles 1, 3, 5, 7; GAP in cycles 2, 4, 6; CALC in cycle 8; `height_valid` high in cycle 9.
  - Minimum start-to-valid is 9 cycles.
  - Each extra ack-wait cycle adds 1.
  - Worst case is 4 × `TIMEOUT` + 5 cycles.
- **Read port:** `sensor_sel` is stable for every cycle `sensor_req` is high; `sensor_ack` is ignored while `sensor_req` = 0.
- **Handshake:**
  - `height` and `height_valid` are stable while `height_ready` = 0.
  - Transfer happens on a cycle with both high.
  - The earliest new `start` is accepted the cycle after the transfer.
- **`timeout_err`:** changes only at the IDLE→REQ transition (clear) and at a timeout (set); it is stable otherwise.

## Test plan
- Sensors 10, 20, 30, 40 with immediate acks → `height` = 25, `height_valid` first high in cycle 9, `timeout_err` = 0.
- Sensors 1, 2, 2, 2 → sum 7, n = 4 → `height` = 2. Sensors 2, 2, 2, 2 → `height` = 2.
- Sensors 50, 11, 0, 12 → pair A invalid; sum 23, n = 2 → `height` = 12.
- Sensor2 never acks, `TIMEOUT` = 15; sensors 40, –, 60, 9 → slot1 = 0, `timeout_err` = 1, `height` = 50, valid in cycle 9 + 14 = 23.
- Ack arrives on exactly the `TIMEOUT`th REQ cycle → data captured, `timeout_err` = 0.
- Backpressure and reset:
  - Hold `height_ready` = 0 for 5 cycles with `start` pulsed in OUT → `height` and `height_valid` hold, the start is ignored, and the return to IDLE follows ready.
  - `rst` asserted mid-REQ → next cycle `sensor_req` = 0, `busy` = 0, `height_valid` = 0, and a following `start` runs a clean frame.
